// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one pipelined in-order memory, with a tag FIFO
// routing read responses back to their issuer. Define ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,

    output logic             o_imem_ready,
    input  logic [31:0]      i_imem_raddr,
    input  logic             i_imem_ren,
    output logic             o_imem_valid,
    output logic [31:0]      o_imem_rdata,

    output logic             o_dmem_ready,
    input  logic [31:0]      i_dmem_addr,
    input  logic             i_dmem_ren,
    input  logic             i_dmem_wen,
    input  logic [31:0]      i_dmem_wdata,
    input  logic [3:0]       i_dmem_mask,
    output logic             o_dmem_valid,
    output logic [31:0]      o_dmem_rdata,

    input  logic             i_mem_ready,
    output logic [31:0]      o_mem_addr,
    output logic             o_mem_ren,
    output logic             o_mem_wen,
    output logic [31:0]      o_mem_wdata,
    output logic [3:0]       o_mem_mask,
    input  logic             i_mem_valid,
    input  logic [31:0]      i_mem_rdata,

    output logic [CNT_W-1:0] o_outstanding,
    output logic             o_err
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic        TAG_IMEM = 1'b0;
    localparam logic        TAG_DMEM = 1'b1;

    logic             tag_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic full;
    logic empty;
    logic imem_elig;
    logic dmem_elig;
    logic gnt_imem;
    logic gnt_dmem;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // Gating with i_rst_n keeps every grant, and therefore every ready/enable, low in reset.
    // A full FIFO blocks reads even when a pop lands in the same cycle.
    assign imem_elig = i_rst_n & i_imem_ren & ~full;
    assign dmem_elig = i_rst_n & ((i_dmem_ren & ~full) | i_dmem_wen);

`ifdef ARB_RR_EN
    logic prio_dmem_q;

    always_comb begin
        gnt_dmem = dmem_elig & (~imem_elig | prio_dmem_q);
        gnt_imem = imem_elig & ~gnt_dmem;
    end

    // Priority flips to the other port only when a request is actually accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio_dmem_q <= 1'b1;
        end else if ((gnt_imem | gnt_dmem) && i_mem_ready) begin
            prio_dmem_q <= gnt_imem;
        end
    end
`else
    always_comb begin
        gnt_dmem = dmem_elig;
        gnt_imem = imem_elig & ~dmem_elig;
    end
`endif

    always_comb begin
        o_mem_addr   = gnt_dmem ? i_dmem_addr : i_imem_raddr;
        o_mem_wdata  = gnt_dmem ? i_dmem_wdata : '0;
        o_mem_mask   = gnt_dmem ? i_dmem_mask : 4'b1111;
        o_mem_ren    = gnt_imem | (gnt_dmem & i_dmem_ren);
        o_mem_wen    = gnt_dmem & i_dmem_wen;
        o_imem_ready = gnt_imem & i_mem_ready;
        o_dmem_ready = gnt_dmem & i_mem_ready;
    end

    assign push = o_mem_ren & i_mem_ready;
    assign pop  = i_mem_valid & ~empty;
    assign head = tag_q[rd_ptr_q];

    // A response with no tag outstanding is dropped here and only flagged through o_err.
    always_comb begin
        o_imem_valid  = pop & (head == TAG_IMEM);
        o_dmem_valid  = pop & (head == TAG_DMEM);
        o_imem_rdata  = i_mem_rdata;
        o_dmem_rdata  = i_mem_rdata;
        o_outstanding = count_q;
        o_err         = err_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                tag_q[i] <= TAG_IMEM;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= gnt_dmem ? TAG_DMEM : TAG_IMEM;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (i_mem_valid && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for the grant/forwarding logic plus
// hand-written multi-cycle sequences against a fixed-latency (4) memory model.
module tb_mem_arbiter;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready, imem_ren, imem_valid;
    logic [31:0] imem_raddr, imem_rdata;
    logic        dmem_ready, dmem_ren, dmem_wen, dmem_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_mask;
    logic        mem_ready, mem_ren, mem_wen, mem_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic [2:0]  outstanding;
    logic        err;
    logic        inject;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_ready(imem_ready), .i_imem_raddr(imem_raddr), .i_imem_ren(imem_ren),
        .o_imem_valid(imem_valid), .o_imem_rdata(imem_rdata),
        .o_dmem_ready(dmem_ready), .i_dmem_addr(dmem_addr), .i_dmem_ren(dmem_ren),
        .i_dmem_wen(dmem_wen), .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask),
        .o_dmem_valid(dmem_valid), .o_dmem_rdata(dmem_rdata),
        .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren),
        .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
        .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata),
        .o_outstanding(outstanding), .o_err(err)
    );

    // Memory model: latency 4, in order, contents derived from the address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    logic [3:0]  pv;
    logic [31:0] pa [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[2:0], mem_ren & mem_ready};
            pa[0] <= mem_addr;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            pa[3] <= pa[2];
        end
    end

    assign mem_valid = pv[3] | inject;
    assign mem_rdata = inject ? 32'hBAD0BAD0 : mem_data(pa[3]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        imem_ren   = 1'b0;
        imem_raddr = '0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_mask  = '0;
        mem_ready  = 1'b1;
        inject     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        ir, dr, dw, rdy;
        logic        ei, ed, eren, ewen;
        logic [31:0] eaddr;
        logic [3:0]  emask;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // ir dr dw rdy | imem_ready dmem_ready ren wen addr mask
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  4'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 4'h3};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 4'h3};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 4'hF};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 4'hF};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 4'h3};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 4'h3};

        // Reset state and table-driven grant checks.
        do_reset();
        #1;
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        for (int i = 0; i < 7; i++) begin
            imem_ren   = vecs[i].ir;
            imem_raddr = 32'h40;
            dmem_ren   = vecs[i].dr;
            dmem_wen   = vecs[i].dw;
            dmem_addr  = 32'h80;
            dmem_wdata = 32'h55;
            dmem_mask  = 4'h3;
            mem_ready  = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_imem_ready", i), 32'(imem_ready), 32'(vecs[i].ei));
            chk($sformatf("vec%0d_dmem_ready", i), 32'(dmem_ready), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_mem_ren", i), 32'(mem_ren), 32'(vecs[i].eren));
            chk($sformatf("vec%0d_mem_wen", i), 32'(mem_wen), 32'(vecs[i].ewen));
            if (vecs[i].eren || vecs[i].ewen) begin
                chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].eaddr);
                chk($sformatf("vec%0d_mem_mask", i), 32'(mem_mask), 32'(vecs[i].emask));
            end
            @(negedge clk);
            clear_inputs();
            repeat (6) @(negedge clk);
        end
        chk("table_drained", 32'(outstanding), 32'd0);

        // 1: single imem read, latency 4.
        do_reset();
        imem_ren   = 1'b1;
        imem_raddr = 32'h10;
        #1;
        chk("t1_mem_ren", 32'(mem_ren), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_mask", 32'(mem_mask), 32'hF);
        chk("t1_imem_ready", 32'(imem_ready), 32'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("t1_outstanding", 32'(outstanding), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            chk($sformatf("t1_imem_valid_c%0d", c), 32'(imem_valid), 32'(c == 4));
            chk($sformatf("t1_dmem_valid_c%0d", c), 32'(dmem_valid), 32'd0);
        end
        chk("t1_imem_rdata", imem_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_outstanding_end", 32'(outstanding), 32'd0);

        // 2: simultaneous reads, dmem first, responses not swapped.
        do_reset();
        imem_ren   = 1'b1;
        imem_raddr = 32'h0;
        dmem_ren   = 1'b1;
        dmem_addr  = 32'h100;
        #1;
        chk("t2_dmem_ready", 32'(dmem_ready), 32'd1);
        chk("t2_imem_ready0", 32'(imem_ready), 32'd0);
        chk("t2_addr0", mem_addr, 32'h100);
        @(negedge clk);
        dmem_ren = 1'b0;
        #1;
        chk("t2_imem_ready1", 32'(imem_ready), 32'd1);
        chk("t2_addr1", mem_addr, 32'h0);
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("t2_resp0_dmem_valid", 32'(dmem_valid), 32'd1);
        chk("t2_resp0_imem_valid", 32'(imem_valid), 32'd0);
        chk("t2_resp0_rdata", dmem_rdata, 32'hA5A50100);
        @(negedge clk);
        #1;
        chk("t2_resp1_imem_valid", 32'(imem_valid), 32'd1);
        chk("t2_resp1_dmem_valid", 32'(dmem_valid), 32'd0);
        chk("t2_resp1_rdata", imem_rdata, 32'hA5A50000);

        // 3: FIFO full blocks reads but not writes; 5th read goes after the first pop.
        do_reset();
        imem_ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            imem_raddr = 32'h20 + 32'(4 * k);
            @(negedge clk);
        end
        imem_raddr = 32'h30;
        #1;
        chk("t3_full_count", 32'(outstanding), 32'd4);
        chk("t3_full_imem_ready", 32'(imem_ready), 32'd0);
        chk("t3_full_mem_ren", 32'(mem_ren), 32'd0);
        chk("t3_first_resp", 32'(imem_valid), 32'd1);
        chk("t3_first_rdata", imem_rdata, 32'hA5A50020);
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h200;
        dmem_mask  = 4'b0011;
        dmem_wdata = 32'hCAFEF00D;
        #1;
        chk("t3_wr_dmem_ready", 32'(dmem_ready), 32'd1);
        chk("t3_wr_mem_wen", 32'(mem_wen), 32'd1);
        chk("t3_wr_addr", mem_addr, 32'h200);
        chk("t3_wr_mask", 32'(mem_mask), 32'h3);
        chk("t3_wr_imem_ready", 32'(imem_ready), 32'd0);
        @(negedge clk);
        dmem_wen = 1'b0;
        #1;
        chk("t3_after_pop_count", 32'(outstanding), 32'd3);
        chk("t3_fifth_ready", 32'(imem_ready), 32'd1);
        chk("t3_fifth_addr", mem_addr, 32'h30);
        chk("t3_second_rdata", imem_rdata, 32'hA5A50024);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("t3_push_pop_count", 32'(outstanding), 32'd3);
        repeat (8) @(negedge clk);
        chk("t3_drained", 32'(outstanding), 32'd0);

        // 4: write held while memory is not ready.
        do_reset();
        mem_ready  = 1'b0;
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h300;
        dmem_wdata = 32'h12345678;
        dmem_mask  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_stall%0d_ready", k), 32'(dmem_ready), 32'd0);
            chk($sformatf("t4_stall%0d_wen", k), 32'(mem_wen), 32'd1);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("t4_accept_ready", 32'(dmem_ready), 32'd1);
        chk("t4_wdata", mem_wdata, 32'h12345678);
        chk("t4_addr", mem_addr, 32'h300);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("t4_no_outstanding", 32'(outstanding), 32'd0);

        // 5: stray response sets sticky error; async reset clears state mid-stream.
        do_reset();
        inject = 1'b1;
        #1;
        chk("t5_stray_imem_valid", 32'(imem_valid), 32'd0);
        chk("t5_stray_dmem_valid", 32'(dmem_valid), 32'd0);
        @(negedge clk);
        inject = 1'b0;
        #1;
        chk("t5_err_set", 32'(err), 32'd1);
        chk("t5_fifo_unchanged", 32'(outstanding), 32'd0);
        repeat (2) @(negedge clk);
        chk("t5_err_sticky", 32'(err), 32'd1);
        imem_ren   = 1'b1;
        imem_raddr = 32'h40;
        @(negedge clk);
        imem_raddr = 32'h44;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("t5_two_outstanding", 32'(outstanding), 32'd2);
        #1;
        imem_ren = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("t5_async_outstanding", 32'(outstanding), 32'd0);
        chk("t5_async_err", 32'(err), 32'd0);
        chk("t5_rst_imem_ready", 32'(imem_ready), 32'd0);
        chk("t5_rst_mem_ren", 32'(mem_ren), 32'd0);
        repeat (2) @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_no_stale_err", 32'(err), 32'd0);

        // 6: both ports requesting continuously.
        do_reset();
        imem_ren   = 1'b1;
        imem_raddr = 32'h0;
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h400;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("t6_c%0d_dmem_ready", k), 32'(dmem_ready),
                32'(RR ? (k % 2 == 0) : 1'b1));
            chk($sformatf("t6_c%0d_imem_ready", k), 32'(imem_ready),
                32'(RR ? (k % 2 == 1) : 1'b0));
            @(negedge clk);
        end
        clear_inputs();
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
